// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, halt word and fetch FSM states for the CPU front end.
package cpu_pkg;
  localparam int DEFAULT_PC_WIDTH = 8;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched words with their addresses.
module fetch_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int PW = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [INSTR_WIDTH-1:0] data_i,
  input  logic [PW-1:0]          pc_i,
  output logic [INSTR_WIDTH-1:0] data_o,
  output logic [PW-1:0]          pc_o,
  output logic [CW-1:0]          count_o
);
  logic [INSTR_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] pc_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign data_o = data_q[rd_q];
  assign pc_o = pc_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '{default: '0};
      pc_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= data_i;
        pc_q[wr_q] <= pc_i;
        wr_q <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, single-outstanding RAM reads and buffered delivery to decode.
// Optional halt-on-0xFFFFFFFF behaviour is enabled by defining IFETCH_HALT_EN.
module instruction_fetch import cpu_pkg::*; #(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] START_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  output logic                   Enable,
  output logic                   RW_ram,
  output logic [15:0]            Address_in,
  input  logic [INSTR_WIDTH-1:0] Out,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    Redirect_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   Inst_valid,
  input  logic                   Inst_ready,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   Halted
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, infl_pc_q;
  logic [15:0] addr_q;
  logic [CW-1:0] count;
  logic issue, capture, halt_hit, push;

  // Issuing only from FETCH keeps one read in flight; reset gating forces Enable low at once.
  always_comb begin
    issue = !Reset && state_q == S_FETCH && !Redirect && count < CW'(FIFO_DEPTH);
    capture = state_q == S_WAIT && !Redirect;
`ifdef IFETCH_HALT_EN
    halt_hit = capture && Out == HALT_WORD;
`else
    halt_hit = 1'b0;
`endif
    push = capture && !halt_hit;
    Address_in = issue ? 16'(fetch_pc_q) : addr_q;
    fetch_pc_d = Redirect ? Redirect_addr : issue ? fetch_pc_q + 1'b1 : fetch_pc_q;
    state_d = Redirect ? S_FETCH : issue ? S_WAIT :
              state_q == S_WAIT ? (halt_hit ? S_HALT : S_FETCH) : state_q;
  end

  assign Enable = issue;
  assign RW_ram = 1'b1;
  assign Inst_valid = count != '0;
`ifdef IFETCH_HALT_EN
  assign Halted = state_q == S_HALT;
`else
  assign Halted = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      fetch_pc_q <= START_PC;
      infl_pc_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (issue) begin
        addr_q <= Address_in;
        infl_pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .PW(PC_WIDTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .push_i(push),
    .pop_i(Inst_valid && Inst_ready),
    .flush_i(Redirect),
    .data_i(Out),
    .pc_i(infl_pc_q),
    .data_o(instruction),
    .pc_o(pc),
    .count_o(count)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random stimulus against a queue-based fetch model.
module tb_instruction_fetch;
  localparam int D = 2;
`ifdef IFETCH_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic Clk = 1'b0, Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic Enable, RW_ram, Inst_valid, Halted;
  logic [15:0] Address_in;
  logic [31:0] Out = '0, instruction;
  logic Redirect = 1'b0, Inst_ready = 1'b1;
  logic [7:0] Redirect_addr = '0, pc;
  logic en2, rw2, v2, h2;
  logic [15:0] addr2;
  logic [31:0] out2 = '0, instr2;
  logic [7:0] pc2;

  logic [31:0] mem [256];
  always @(posedge Clk) if (Enable) Out <= mem[Address_in[7:0]];
  always @(posedge Clk) if (en2) out2 <= mem[addr2[7:0]];

  instruction_fetch u_dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .RW_ram(RW_ram), .Address_in(Address_in),
    .Out(Out), .Redirect(Redirect), .Redirect_addr(Redirect_addr), .instruction(instruction),
    .Inst_valid(Inst_valid), .Inst_ready(Inst_ready), .pc(pc), .Halted(Halted)
  );

  instruction_fetch #(.START_PC(8'hFE)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Enable(en2), .RW_ram(rw2), .Address_in(addr2),
    .Out(out2), .Redirect(1'b0), .Redirect_addr(8'h00), .instruction(instr2),
    .Inst_valid(v2), .Inst_ready(1'b1), .pc(pc2), .Halted(h2)
  );

  // Reference model: buffered words, one optional outstanding read, next fetch address.
  logic [39:0] mbuf [$];
  logic [39:0] got [$], got2 [$];
  bit infl, mhalt;
  logic [31:0] infl_d;
  logic [7:0] infl_pc, fpc;
  logic [15:0] last_addr;
  int checks = 0, errors = 0, cyc = 0, first_en = -1, first_v = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mbuf.delete();
    infl = 0;
    mhalt = 0;
    fpc = 8'h00;
    last_addr = '0;
  endtask

  task automatic cycle();
    logic e;
    logic [15:0] a;
    @(negedge Clk);
    e = !Reset && !infl && !mhalt && mbuf.size() < D && !Redirect;
    a = Reset ? 16'h0 : e ? {8'h00, fpc} : last_addr;
    chk("enable", Enable, e);
    chk("address", Address_in, a);
    chk("valid", Inst_valid, !Reset && mbuf.size() > 0);
    if (!Reset && mbuf.size() > 0) begin
      chk("instruction", instruction, mbuf[0][31:0]);
      chk("pc", pc, mbuf[0][39:32]);
    end
    chk("halted", Halted, mhalt);
    if (!Reset && Inst_valid && Inst_ready) got.push_back({pc, instruction});
    if (!Reset && v2) got2.push_back({pc2, instr2});
    if (first_en < 0 && Enable) first_en = cyc;
    if (first_v < 0 && Inst_valid) first_v = cyc;
    @(posedge Clk);
    if (Reset) mreset();
    else begin
      if (mbuf.size() > 0 && Inst_ready) void'(mbuf.pop_front());
      if (Redirect) begin
        mbuf.delete();
        infl = 0;
        mhalt = 0;
        fpc = Redirect_addr;
      end else begin
        if (infl) begin
          infl = 0;
          if (HALT_ON && infl_d == 32'hFFFF_FFFF) mhalt = 1;
          else mbuf.push_back({infl_pc, infl_d});
        end
        if (e) begin
          infl = 1;
          infl_pc = fpc;
          infl_d = mem[fpc];
          last_addr = {8'h00, fpc};
          fpc = fpc + 8'h01;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [7:0] lastp;
    logic [39:0] hp;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[254] = 32'hAAAA_0001; mem[255] = 32'hAAAA_0002;
    mreset();
    #1 Reset = 1'b1;
    #1;
    chk("rst_enable", Enable, 0);
    chk("rst_address", Address_in, 0);
    chk("rst_valid", Inst_valid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", Halted, 0);
    chk("rw_ram", RW_ram, 1);
    run(2);
    Reset = 1'b0;
    cyc = 0; first_en = -1; first_v = -1;
    got.delete(); got2.delete();
    run(12);
    chk("latency", first_v - first_en, 2);
    chk("startup_count", got.size() >= 4, 1);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("startup_word", got[i], {8'(i), mem[i]});
    chk("wrap_count", got2.size() >= 3, 1);
    if (got2.size() >= 3) begin
      chk("wrap_fe", got2[0], {8'hFE, 32'hAAAA_0001});
      chk("wrap_ff", got2[1], {8'hFF, 32'hAAAA_0002});
      chk("wrap_00", got2[2], {8'h00, 32'h11});
    end

    lastp = got[got.size()-1][39:32];
    Inst_ready = 1'b0;
    run(4);
    hp = {pc, instruction};
    run(6);
    chk("stall_enable", Enable, 0);
    chk("stall_buffered", mbuf.size(), 2);
    chk("stall_stable", {pc, instruction}, hp);
    Inst_ready = 1'b1;
    got.delete();
    run(12);
    chk("resume_count", got.size() >= 4, 1);
    for (int i = 0; i < got.size(); i++) begin
      chk("resume_seq", got[i][39:32], 8'(lastp + 8'(i + 1)));
      chk("resume_data", got[i][31:0], mem[got[i][39:32]]);
    end

    Inst_ready = 1'b0;
    k = 0;
    while (!(infl && mbuf.size() == 1) && k < 10) begin cycle(); k++; end
    chk("redirect_setup", infl && mbuf.size() == 1, 1);
    Redirect = 1'b1; Redirect_addr = 8'h40;
    cycle();
    Redirect = 1'b0; Inst_ready = 1'b1;
    got.delete();
    run(8);
    chk("redirect_first", got.size() > 0 ? got[0] : 40'h0, {8'h40, mem[8'h40]});

    Inst_ready = 1'b0;
    k = 0;
    while (mbuf.size() != 2 && k < 10) begin cycle(); k++; end
    chk("redirect2_setup", mbuf.size(), 2);
    hp = mbuf[0];
    got.delete();
    Inst_ready = 1'b1; Redirect = 1'b1; Redirect_addr = 8'h80;
    cycle();
    Redirect = 1'b0;
    run(8);
    chk("redirect_xfer_head", got.size() > 1 ? got[0] : 40'h0, hp);
    chk("redirect_xfer_next", got.size() > 1 ? got[1] : 40'h0, {8'h80, mem[8'h80]});

    for (int i = 0; i < 400; i++) begin
      Inst_ready = $urandom_range(0, 3) != 0;
      Redirect = $urandom_range(0, 19) == 0;
      Redirect_addr = 8'($urandom);
      cycle();
    end
    Redirect = 1'b0; Inst_ready = 1'b1;

    Reset = 1'b1;
    mem[2] = 32'hFFFF_FFFF;
    run(2);
    Reset = 1'b0;
    got.delete();
    run(15);
`ifdef IFETCH_HALT_EN
    chk("halt_flag", Halted, 1);
    chk("halt_enable", Enable, 0);
    chk("halt_count", got.size(), 2);
    chk("halt_w0", got.size() > 1 ? got[0] : 40'h0, {8'h00, 32'h11});
    chk("halt_w1", got.size() > 1 ? got[1] : 40'h0, {8'h01, 32'h22});
    Redirect = 1'b1; Redirect_addr = 8'h00;
    cycle();
    Redirect = 1'b0;
    chk("halt_cleared", Halted, 0);
    got.delete();
    run(6);
    chk("halt_refetch", got.size() > 0 ? got[0] : 40'h0, {8'h00, 32'h11});
`else
    chk("nohalt_count", got.size() >= 3, 1);
    chk("nohalt_w2", got.size() >= 3 ? got[2] : 40'h0, {8'h02, 32'hFFFF_FFFF});
    chk("nohalt_flag", Halted, 0);
`endif

    run(3);
    Reset = 1'b1;
    #1;
    chk("midrst_enable", Enable, 0);
    chk("midrst_address", Address_in, 0);
    chk("midrst_valid", Inst_valid, 0);
    chk("midrst_instruction", instruction, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_halted", Halted, 0);
    mreset();
    run(2);
    Reset = 1'b0;
    got.delete();
    run(8);
    chk("restart_first", got.size() > 0 ? got[0] : 40'h0, {8'h00, 32'h11});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
